// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and I/O port address constants
package cpu_pkg;

  // Common accumulator / data bus width
  localparam int DATA_W = 8;

  // Port address the I/O decoder maps to the accumulator output port
  localparam logic [3:0] OUT_PORT_ADDR = 4'h1;

endpackage : cpu_pkg

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, sync write port, async read port
module fifo_mem
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never cleared; valid words are tracked by the pointers
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/acc_out_port.sv
// rtl/acc_out_port.sv - accumulator output port FIFO with sticky overflow
module acc_out_port
  import cpu_pkg::*;
#(
  parameter int   WIDTH = DATA_W,
  parameter int   DEPTH = 4,
  localparam int  CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_ovf,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_acc, rd_acc, wr_drop;
  logic [WIDTH-1:0] head_word;

  // Flags come from registered count only, so no input reaches an output
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : head_word;
  assign count    = count_q;
  assign overflow = overflow_q;

  assign wr_acc  = wr_en && !full;
  assign wr_drop = wr_en && full;
  assign rd_acc  = rd_valid && rd_ready;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (head_word)
  );

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_acc) begin
      wr_ptr_d = AW'(wr_ptr_q + 1'b1);
    end
    if (rd_acc) begin
      rd_ptr_d = AW'(rd_ptr_q + 1'b1);
    end

    if (wr_acc && !rd_acc) begin
      count_d = CW'(count_q + 1'b1);
    end else if (rd_acc && !wr_acc) begin
      count_d = CW'(count_q - 1'b1);
    end

    // A dropped write outranks a clear arriving in the same cycle
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // State registers; reset discards everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule : acc_out_port

// File: tb/tb_acc_out_port.sv
// tb/tb_acc_out_port.sv - randomized and directed check of acc_out_port
module tb_acc_out_port;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         clr_ovf;
  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic         full;
  logic         empty;
  logic [2:0]   count;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference: a plain queue of stored words plus a sticky flag
  logic [W-1:0] mq[$];
  bit           m_ovf;

  acc_out_port #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs seen at that edge
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      bit was_full;
      bit take;
      was_full = (mq.size() == D);
      take     = (mq.size() > 0) && rd_ready;
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (clr_ovf)      m_ovf = 1'b0;
      if (take) void'(mq.pop_front());
      if (wr_en && !was_full) mq.push_back(wr_data);
    end
  end

  // Every cycle: DUT outputs against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("count",    int'(count),    mq.size());
      cmp("empty",    int'(empty),    int'(mq.size() == 0));
      cmp("full",     int'(full),     int'(mq.size() == D));
      cmp("rd_valid", int'(rd_valid), int'(mq.size() != 0));
      cmp("rd_data",  int'(rd_data),  (mq.size() != 0) ? int'(mq[0]) : 0);
      cmp("overflow", int'(overflow), int'(m_ovf));
    end
  end

  // Apply one cycle of inputs; returns at the following falling edge
  task automatic tick(input bit we, input logic [W-1:0] wd, input bit rr,
                      input bit clr, input bit r);
    wr_en    = we;
    wr_data  = wd;
    rd_ready = rr;
    clr_ovf  = clr;
    rst      = r;
    @(negedge clk);
  endtask

  task automatic idle();
    tick(0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    idle();
    chk_en = 1'b1;

    // 1: reset then idle
    cmp("t1_empty", int'(empty), 1);
    cmp("t1_full", int'(full), 0);
    cmp("t1_count", int'(count), 0);
    cmp("t1_valid", int'(rd_valid), 0);
    cmp("t1_data", int'(rd_data), 0);
    cmp("t1_ovf", int'(overflow), 0);

    // 2: single word, held while not ready
    tick(1, 8'hA5, 0, 0, 0);
    cmp("t2_valid", int'(rd_valid), 1);
    cmp("t2_count", int'(count), 1);
    for (int i = 0; i < 3; i++) begin
      cmp("t2_data_hold", int'(rd_data), 8'hA5);
      idle();
    end
    tick(0, 8'h00, 1, 0, 0);
    cmp("t2_empty", int'(empty), 1);

    // 3: fill, overflow, drain in order, clear
    for (int i = 1; i <= 4; i++) tick(1, 8'(i), 0, 0, 0);
    cmp("t3_full", int'(full), 1);
    cmp("t3_count4", int'(count), 4);
    tick(1, 8'h05, 0, 0, 0);
    cmp("t3_ovf", int'(overflow), 1);
    cmp("t3_count_hold", int'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      cmp("t3_drain", int'(rd_data), i);
      tick(0, 8'h00, 1, 0, 0);
    end
    cmp("t3_empty", int'(empty), 1);
    cmp("t3_ovf_sticky", int'(overflow), 1);
    tick(0, 8'h00, 0, 1, 0);
    cmp("t3_ovf_clr", int'(overflow), 0);

    // overflow with a simultaneous read; set beats clear
    for (int i = 0; i < 4; i++) tick(1, 8'h40 + 8'(i), 0, 0, 0);
    tick(1, 8'h99, 1, 1, 0);
    cmp("ovf_rd_count", int'(count), 3);
    cmp("ovf_set_wins", int'(overflow), 1);
    cmp("ovf_rd_head", int'(rd_data), 8'h41);
    tick(0, 8'h00, 0, 0, 1);

    // 4: simultaneous write and read at count 2
    tick(1, 8'h10, 0, 0, 0);
    tick(1, 8'h11, 0, 0, 0);
    tick(1, 8'h12, 1, 0, 0);
    cmp("t4_count", int'(count), 2);
    cmp("t4_head", int'(rd_data), 8'h11);
    tick(0, 8'h00, 1, 0, 0);
    cmp("t4_next", int'(rd_data), 8'h12);
    tick(0, 8'h00, 1, 0, 0);
    cmp("t4_empty", int'(empty), 1);

    // 5: wrap-around pairs
    for (int i = 0; i < 10; i++) begin
      tick(1, 8'h20 + 8'(i), 0, 0, 0);
      cmp("t5_data", int'(rd_data), 8'h20 + i);
      cmp("t5_count_le1", int'(count <= 3'd1), 1);
      tick(0, 8'h00, 1, 0, 0);
    end

    // 6: reset mid-operation
    for (int i = 0; i < 3; i++) tick(1, 8'h60 + 8'(i), 0, 0, 0);
    cmp("t6_count3", int'(count), 3);
    tick(1, 8'hEE, 1, 0, 1);
    cmp("t6_count0", int'(count), 0);
    cmp("t6_empty", int'(empty), 1);
    tick(1, 8'h7E, 0, 0, 0);
    cmp("t6_first", int'(rd_data), 8'h7E);
    tick(0, 8'h00, 1, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_acc_out_port

// File: doc/acc_out_port.md
Name: acc_out_port

Overview:
- Output-side counterpart of the accumulator: the CPU pushes accumulator values out through this block, and an external consumer drains them.
- A store-to-port instruction writes the current accumulator value. The block buffers it in a small FIFO.
- The consumer reads words with a valid/ready handshake.
- Status flags (full, empty, overflow) return to the control unit so programs can poll before writing.

Parameters:
- WIDTH, 8, data word width; must match the accumulator width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), count width; derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  CPU write strobe; one word per cycle.
- wr_data  input  WIDTH  accumulator value to enqueue.
- clr_ovf  input  1  clears the sticky overflow flag.
- rd_valid  output  1  head word present on rd_data.
- rd_ready  input  1  consumer accepts head word.
- rd_data  output  WIDTH  head word, first-word-fall-through.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CW  number of stored words.
- overflow  output  1  sticky; a write was dropped.

Behaviour:
- Reset (rst high at posedge):
  - wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0.
  - Outputs after reset: empty = 1, full = 0, rd_valid = 0, rd_data = 0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all buffered words in that cycle. Any wr_en or rd_ready in the reset cycle is ignored.
- Derived outputs (all from registered state only, so no combinational path from inputs):
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr] when !empty, else all zeros.
  - full and empty decode from count.
- Write acceptance: wr_acc = wr_en && !full, using the registered full flag.
  - An accepted write stores wr_data at mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Read acceptance: rd_acc = rd_valid && rd_ready.
  - An accepted read increments rd_ptr modulo DEPTH.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither occur.
- Latency: a word written at edge N is visible with rd_valid = 1 from edge N onward, i.e. during cycle N+1. There is no same-cycle bypass when empty.
- Full with wr_en high:
  - The write is dropped and overflow is set at that edge.
  - This holds even if rd_acc occurs in the same cycle; the read still completes, so count drops by 1.
- Empty with rd_ready high: no effect, pointers hold.
- Empty with wr_en high: the write is stored. rd_ready in that cycle has no effect.
- Simultaneous write and read when neither full nor empty: both proceed and count holds.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- overflow:
  - Set by a dropped write; cleared by clr_ovf or rst.
  - If set and clr_ovf occur in the same cycle, set wins.
- Consumer handshake: rd_data stays stable while rd_valid = 1 and rd_ready = 0.

Decomposition:
- Shared package (cpu_pkg): DATA_W = 8 (common accumulator/bus width) and the port-address constant for the output port, used by the decoder.
- One sub-module, fifo_mem: DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port, indexed by pointers.
- Pointer, count and flag logic stay in acc_out_port.

Test Plan:
1. Reset then idle: rst high 1 cycle -> empty = 1, full = 0, count = 0, rd_valid = 0, rd_data = 0x00, overflow = 0.
2. Single word: wr_en with 0xA5 for 1 cycle, rd_ready = 0 -> next cycle rd_valid = 1, rd_data = 0xA5, count = 1. Hold rd_ready = 0 for 3 cycles -> data stable. Pulse rd_ready -> empty = 1.
3. Fill and overflow: write 0x01, 0x02, 0x03, 0x04 -> full = 1, count = 4. Write 0x05 -> dropped, overflow = 1. Drain -> reads 0x01..0x04 in order; 0x05 never appears. Pulse clr_ovf -> overflow = 0.
4. Simultaneous: with count = 2 (0x10, 0x11), wr_en 0x12 with rd_ready high -> count stays 2, rd_data becomes 0x11. Next reads give 0x11 then 0x12.
5. Wrap-around: 10 write/read pairs of 0x20..0x29 with both pointers cycling past DEPTH -> output order is 0x20..0x29 and count never exceeds 1.
6. Reset mid-operation: count = 3, assert rst together with wr_en and rd_ready -> next cycle count = 0, empty = 1. A subsequent write of 0x7E is read back as the first word.
